// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with a registered one-hot grant held until acknowledged
//   clk        clock
//   arst_n     asynchronous active-low reset
//   i_req      request vector, bit i = requester i
//   i_ack      consumer accepts the current grant (ignored while idle)
//   o_gnt_vld  grant valid
//   o_gnt      one-hot grant, zero while idle
//   o_gnt_idx  binary index of o_gnt, zero while idle
module pri #(
    parameter int W = 4
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);
    assign gnt = req & (~req + W'(1));
endmodule

module rr_arb #(
    parameter  int W     = 4,
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [W-1:0]     i_req,
    input  logic             i_ack,
    output logic             o_gnt_vld,
    output logic [W-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state, state_n;
    logic [W-1:0]     mask, mask_n, gnt, gnt_n, above, use_mask, m, m_gnt, r_gnt, sel;
    logic [IDX_W-1:0] idx, idx_n, sel_idx;
    // on an ack the pointer moves past the granted requester before the next pick
    assign above    = (idx == IDX_W'(W - 1)) ? '1 : ~(gnt | (gnt - W'(1)));
    assign use_mask = (state == GRANT && i_ack) ? above : mask;
    assign m        = i_req & use_mask;
    pri #(.W(W)) u_pri_m (.req(m),     .gnt(m_gnt));
    pri #(.W(W)) u_pri_r (.req(i_req), .gnt(r_gnt));
    assign sel = |m ? m_gnt : r_gnt;
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < W; i++)
            if (sel[i]) sel_idx = IDX_W'(i);
    end
    always_comb begin
        state_n = state;
        mask_n  = mask;
        gnt_n   = gnt;
        idx_n   = idx;
        if (state == IDLE) begin
            if (|i_req) begin
                state_n = GRANT;
                gnt_n   = sel;
                idx_n   = sel_idx;
            end
        end else if (i_ack) begin
            mask_n  = above;
            state_n = |sel ? GRANT : IDLE;
            gnt_n   = sel;
            idx_n   = sel_idx;
        end
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            mask  <= '1;
            gnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            mask  <= mask_n;
            gnt   <= gnt_n;
            idx   <= idx_n;
        end
    end
    assign o_gnt_vld = (state == GRANT);
    assign o_gnt     = gnt;
    assign o_gnt_idx = idx;
    a_onehot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(o_gnt));
    a_vld:    assert property (@(posedge clk) disable iff (!arst_n) o_gnt_vld == |o_gnt);
    a_hold:   assert property (@(posedge clk) disable iff (!arst_n) o_gnt_vld && !i_ack |=> $stable(o_gnt));
endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb: randomized and directed scoreboard bench for rr_arb
module tb_rr_arb;
    localparam int W = 4;
    localparam int IDX_W = 2;
    localparam int EW = 1 + W + IDX_W;
    logic             clk = 0;
    logic             arst_n = 0;
    logic [W-1:0]     i_req = '0;
    logic             i_ack = 0;
    logic             o_gnt_vld;
    logic [W-1:0]     o_gnt;
    logic [IDX_W-1:0] o_gnt_idx;
    logic [EW-1:0]    exp_q[$];
    int               errors = 0, checks = 0;
    int               g = -1, p = 0;
    rr_arb #(.W(W)) dut (
        .clk(clk), .arst_n(arst_n), .i_req(i_req), .i_ack(i_ack),
        .o_gnt_vld(o_gnt_vld), .o_gnt(o_gnt), .o_gnt_idx(o_gnt_idx)
    );
    always #5 clk = ~clk;
    function automatic int choose(logic [W-1:0] req, int ptr);
        for (int k = 0; k < W; k++)
            if (req[(ptr + k) % W]) return (ptr + k) % W;
        return -1;
    endfunction
    function automatic logic [EW-1:0] expect_of(int gi);
        logic [W-1:0] oh;
        oh = (gi >= 0) ? W'(1) << gi : '0;
        return {gi >= 0, oh, (gi >= 0) ? IDX_W'(gi) : IDX_W'(0)};
    endfunction
    task automatic step(input logic [W-1:0] req, input logic ack);
        i_req = req;
        i_ack = ack;
        if (g < 0) g = choose(req, p);
        else if (ack) begin
            p = (g + 1) % W;
            g = choose(req, p);
        end
        @(posedge clk);
        exp_q.push_back(expect_of(g));
        #1;
    endtask
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got vld/gnt/idx=%b expected %b", name, act, req_v);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        #1;
        arst_n = 0;
        g = -1;
        p = 0;
        #1;
        check("async_reset", {o_gnt_vld, o_gnt, o_gnt_idx}, '0);
        @(posedge clk);
        #1;
        arst_n = 1;
    endtask
    always @(negedge clk)
        if (exp_q.size() > 0) check("grant", {o_gnt_vld, o_gnt, o_gnt_idx}, exp_q.pop_front());
    initial begin
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1;
        do_reset();
        repeat (10) step(4'b0000, 0);
        repeat (6) step(4'b1111, 1);
        do_reset();
        step(4'b1010, 0);
        repeat (3) step(4'b1010, 1);
        do_reset();
        step(4'b0100, 0);
        repeat (5) step(4'b0100, 0);
        repeat (3) step(4'b0001, 0);
        step(4'b0001, 1);
        step(4'b0001, 0);
        step(4'b0000, 1);
        step(4'b1000, 0);
        step(4'b1001, 1);
        step(4'b1001, 1);
        step(4'b0000, 1);
        do_reset();
        step(4'b0100, 0);
        step(4'b0100, 0);
        do_reset();
        step(4'b1100, 0);
        step(4'b1100, 1);
        step(4'b1100, 1);
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 3) != 0));
        end
        step(4'b0000, 1);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
